// File: rtl/matvec_mac_sequencer_pkg.sv
// matvec_pkg: shared state encoding and default widths for the matrix-vector MAC sequencer
package matvec_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} seq_state_t;
  localparam int DATA_WIDTH_D = 8;
  localparam int ACC_WIDTH_D = 24;
endpackage

// File: rtl/matvec_mac_sequencer_mac_unit.sv
// mac_unit: registered unsigned multiply-accumulate lane with clear over enable
module mac_unit
  import matvec_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int ACC_WIDTH  = ACC_WIDTH_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_acc,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);
  logic [2*DATA_WIDTH-1:0] prod;
  assign prod = a * b;
  always_ff @(posedge clk)
    acc <= (rst || clr_acc) ? '0 : en ? acc + ACC_WIDTH'(prod) : acc;
endmodule

// File: rtl/matvec_mac_sequencer.sv
// matvec_mac_sequencer: pops A-row and B-vector FIFOs in lockstep and accumulates per-lane dot products
module matvec_mac_sequencer
  import matvec_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int NUM_MACS   = 8,
  parameter int VEC_LEN    = 8,
  parameter int ACC_WIDTH  = ACC_WIDTH_D,
  parameter int RD_LATENCY = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                clr,
  input  logic [NUM_MACS-1:0][DATA_WIDTH-1:0] fifo_a_q,
  input  logic [NUM_MACS-1:0]                 fifo_a_empty,
  output logic [NUM_MACS-1:0]                 fifo_a_rden,
  input  logic [DATA_WIDTH-1:0]               fifo_b_q,
  input  logic                                fifo_b_empty,
  output logic                                fifo_b_rden,
  output logic [NUM_MACS-1:0][ACC_WIDTH-1:0]  result,
  output logic                                result_valid,
  output logic                                busy,
  output logic [1:0]                          state_out
);
  localparam int CW = $clog2(VEC_LEN + 1);
  if (ACC_WIDTH < 2 * DATA_WIDTH + $clog2(VEC_LEN)) begin : g_acc_chk
    $error("ACC_WIDTH too narrow for DATA_WIDTH and VEC_LEN");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_lat_chk
    $error("RD_LATENCY must be 1..3");
  end
  seq_state_t state, state_n;
  logic [CW-1:0] issue_cnt;
  logic [RD_LATENCY-1:0] vpipe;
  logic pop, launch, clr_acc;
  assign launch = start && (state == IDLE || state == DONE);
  assign pop = !rst && !clr && state == RUN && !(|fifo_a_empty) && !fifo_b_empty && issue_cnt < CW'(VEC_LEN);
  assign clr_acc = clr || launch;
  assign fifo_a_rden = {NUM_MACS{pop}};
  assign fifo_b_rden = pop;
  assign busy = state == RUN || state == DRAIN;
  assign result_valid = state == DONE;
  assign state_out = state;
  always_comb begin
    state_n = state;
    state_n = clr ? IDLE
            : state == IDLE ? (start ? RUN : IDLE)
            : state == RUN ? ((pop && issue_cnt == CW'(VEC_LEN - 1)) ? DRAIN : RUN)
            : state == DRAIN ? (vpipe == '0 ? DONE : DRAIN)
            : (start ? RUN : DONE);
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
    issue_cnt <= (rst || clr || launch) ? '0 : pop ? issue_cnt + 1'b1 : issue_cnt;
    vpipe <= (rst || clr) ? '0 : RD_LATENCY'({vpipe, pop});
  end
  for (genvar i = 0; i < NUM_MACS; i++) begin : g_mac
    mac_unit #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
      .clk(clk),
      .rst(rst),
      .clr_acc(clr_acc),
      .en(vpipe[RD_LATENCY-1]),
      .a(fifo_a_q[i]),
      .b(fifo_b_q),
      .acc(result[i])
    );
  end
endmodule

// File: tb/tb_matvec_mac_sequencer.sv
// tb_matvec_mac_sequencer: table-driven scoreboard bench with FIFO model for the MAC sequencer
module tb_matvec_mac_sequencer;
  logic clk, rst, start, clr;
  logic [7:0][7:0] fifo_a_q;
  logic [7:0] fifo_a_empty, fifo_a_rden;
  logic [7:0] fifo_b_q;
  logic fifo_b_empty, fifo_b_rden;
  logic [7:0][23:0] result;
  logic result_valid, busy;
  logic [1:0] state_out;

  matvec_mac_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .clr(clr),
    .fifo_a_q(fifo_a_q), .fifo_a_empty(fifo_a_empty), .fifo_a_rden(fifo_a_rden),
    .fifo_b_q(fifo_b_q), .fifo_b_empty(fifo_b_empty), .fifo_b_rden(fifo_b_rden),
    .result(result), .result_valid(result_valid), .busy(busy), .state_out(state_out)
  );

  typedef struct {
    int a_mode; int b_mode; int st_after; int st_len; logic st_b; logic [7:0] st_a;
    int lat; int exp0; string name;
  } vec_t;
  typedef struct { logic [7:0][23:0] res; int lat; string name; } exp_t;

  vec_t vecs [5];
  exp_t sb [$];
  int tests = 0, fails = 0, viol = 0, cyc = 0, start_cyc = 0;
  int amode = 0, bmode = 1, flen = 0, b_ptr = 0;
  int a_ptr [8];
  int st_after = 0, st_len = 0, st_cnt = 0;
  logic st_arm = 0, st_b = 0, got = 0;
  logic [7:0] st_a = 0;

  function automatic int a_val(input int m, input int i, input int k);
    return m == 0 ? i + 1 : m == 1 ? 255 : (i * 37 + k * 11 + 5) % 256;
  endfunction
  function automatic int b_val(input int m, input int k);
    return m == 0 ? k + 1 : m;
  endfunction

  task automatic chk(input string nm, input longint got_v, input longint req_v);
    tests++;
    if (got_v != req_v) begin
      fails++;
      $display("FAIL %s got %0d required %0d", nm, got_v, req_v);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running required finished");
    $fatal(1, "timeout");
  end

  // FIFO model: rden observed mid-cycle, read data presented one cycle later
  initial begin
    logic [7:0] ra;
    logic rb;
    forever begin
      @(negedge clk);
      ra = fifo_a_rden;
      rb = fifo_b_rden;
      if ((rb && fifo_b_empty) || |(ra & fifo_a_empty) || ra !== {8{rb}}) viol++;
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < 8; i++)
        if (ra[i]) begin
          fifo_a_q[i] = 8'(a_val(amode, i, a_ptr[i]));
          a_ptr[i]++;
        end
      if (rb) begin
        fifo_b_q = 8'(b_val(bmode, b_ptr));
        b_ptr++;
      end
      if (st_cnt > 0) st_cnt--;
      if (st_arm && b_ptr == st_after) begin
        st_cnt = st_len;
        st_arm = 0;
      end
      fifo_b_empty = b_ptr >= flen || (st_b && st_cnt > 0);
      for (int i = 0; i < 8; i++) fifo_a_empty[i] = a_ptr[i] >= flen || (st_a[i] && st_cnt > 0);
    end
  end

  // scoreboard consumer: compares on each rising edge of result_valid
  initial begin
    logic prev;
    exp_t e;
    prev = 0;
    forever begin
      @(negedge clk);
      if (result_valid && !prev) begin
        got = 1;
        if (sb.size() == 0) chk("unexpected_result_valid", 1, 0);
        else begin
          e = sb.pop_front();
          for (int i = 0; i < 8; i++) chk($sformatf("%s_lane%0d", e.name, i), result[i], e.res[i]);
          chk($sformatf("%s_latency", e.name), cyc - start_cyc, e.lat);
        end
      end
      prev = result_valid;
    end
  end

  task automatic load(input int am, input int bm);
    amode = am;
    bmode = bm;
    for (int i = 0; i < 8; i++) a_ptr[i] = 0;
    b_ptr = 0;
    flen = 8;
  endtask

  task automatic do_start(input string nm);
    @(negedge clk);
    got = 0;
    start = 1;
    @(posedge clk);
    #2;
    start_cyc = cyc;
    start = 0;
    chk({nm, "_busy_after_start"}, {busy, result_valid}, 2'b10);
  endtask

  task automatic wait_done(input string nm);
    for (int t = 0; t < 60 && !got; t++) @(negedge clk);
    if (!got) chk({nm, "_done_timeout"}, 0, 1);
  endtask

  task automatic run_row(input vec_t v);
    exp_t e;
    int s;
    load(v.a_mode, v.b_mode);
    st_after = v.st_after;
    st_len = v.st_len;
    st_b = v.st_b;
    st_a = v.st_a;
    st_arm = v.st_len > 0;
    for (int i = 0; i < 8; i++) begin
      s = 0;
      for (int k = 0; k < 8; k++) s += a_val(v.a_mode, i, k) * b_val(v.b_mode, k);
      e.res[i] = 24'(s);
    end
    e.lat = v.lat;
    e.name = v.name;
    sb.push_back(e);
    do_start(v.name);
    wait_done(v.name);
    s = 0;
    for (int i = 0; i < 8; i++) s += (a_ptr[i] == 8) ? 1 : 0;
    chk({v.name, "_pop_counts"}, s * 16 + b_ptr, 8 * 16 + 8);
    chk({v.name, "_rden_violations"}, viol, 0);
    if (v.exp0 >= 0) chk({v.name, "_lane0_const"}, result[0], v.exp0);
  endtask

  initial begin
    vecs[0] = '{0, 1, 0, 0, 1'b0, 8'h00, 10, 8, "basic"};
    vecs[1] = '{0, 2, 0, 0, 1'b0, 8'h00, 10, 16, "restart_b2"};
    vecs[2] = '{1, 255, 0, 0, 1'b0, 8'h00, 10, 520200, "maxval"};
    vecs[3] = '{0, 1, 4, 3, 1'b1, 8'h00, 13, 8, "b_stall"};
    vecs[4] = '{2, 0, 2, 2, 1'b0, 8'h20, 12, -1, "a5_starve"};
    rst = 1;
    start = 0;
    clr = 0;
    fifo_a_q = '0;
    fifo_b_q = '0;
    fifo_a_empty = '1;
    fifo_b_empty = 1;
    for (int i = 0; i < 8; i++) a_ptr[i] = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_state", state_out, 0);
    chk("reset_flags", {busy, result_valid}, 0);
    chk("reset_result_zero", result == '0, 1);
    chk("reset_rden", {fifo_a_rden, fifo_b_rden}, 0);
    rst = 0;
    for (int r = 0; r < 5; r++) run_row(vecs[r]);

    st_arm = 0;
    st_cnt = 0;
    load(0, 1);
    do_start("clr");
    for (int t = 0; t < 30 && b_ptr < 5; t++) begin
      @(posedge clk);
      #2;
    end
    chk("clr_reached_5_pops", b_ptr, 5);
    clr = 1;
    #1;
    chk("clr_rden_same_cycle", {fifo_a_rden, fifo_b_rden}, 0);
    @(posedge clk);
    #2;
    clr = 0;
    chk("clr_state_idle", state_out, 0);
    chk("clr_result_zero", result == '0, 1);
    chk("clr_flags", {busy, result_valid}, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("clr_no_further_pops", b_ptr, 5);
    run_row(vecs[0]);

    load(2, 0);
    do_start("rst_drain");
    for (int t = 0; t < 30 && state_out != 2; t++) begin
      @(posedge clk);
      #2;
    end
    chk("rst_drain_reached", state_out, 2);
    rst = 1;
    @(posedge clk);
    #2;
    chk("rst_drain_state", state_out, 0);
    chk("rst_drain_flags", {busy, result_valid}, 0);
    chk("rst_drain_result_zero", result == '0, 1);
    chk("rst_drain_rden", {fifo_a_rden, fifo_b_rden}, 0);
    rst = 0;
    repeat (15) @(negedge clk);
    chk("final_rden_violations", viol, 0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/matvec_mac_sequencer.md
Name: matvec_mac_sequencer

Overview:
- Downstream consumer of the memory controller's nine FIFOs: NUM_MACS A-row FIFOs plus one B-vector FIFO.
- After start, pops one element from every FIFO per beat and broadcasts the B element to NUM_MACS multiply-accumulate lanes. Lane i computes result[i] = sum over k of A[i][k]*B[k].
- Holds the finished result vector for the host/readback logic.

Parameters:
- DATA_WIDTH, 8, element width (unsigned).
- NUM_MACS, 8, number of lanes, one per A FIFO.
- VEC_LEN, 8, elements popped per FIFO per run.
- ACC_WIDTH, 24, accumulator width; must be >= 2*DATA_WIDTH+$clog2(VEC_LEN), checked by elaboration assertion.
- RD_LATENCY, 1, cycles from rden to valid q on the FIFOs (range 1-3).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin run; tied to the memory controller's done
- clr  in  1  abort/clear to IDLE
- fifo_a_q  in  [NUM_MACS][DATA_WIDTH]  A FIFO read data
- fifo_a_empty  in  NUM_MACS  A FIFO empty flags
- fifo_a_rden  out  NUM_MACS  A FIFO pops
- fifo_b_q  in  DATA_WIDTH  B FIFO read data
- fifo_b_empty  in  1  B FIFO empty
- fifo_b_rden  out  1  B FIFO pop
- result  out  [NUM_MACS][ACC_WIDTH]  accumulated dot products
- result_valid  out  1  result is final
- busy  out  1  high in RUN or DRAIN
- state_out  out  2  current state, for debug

Behaviour:
- One clock. Reset is synchronous and active-high: the rst port, sampled on the rising edge of clk.
- Reset values: state IDLE; all rden 0; result 0; result_valid 0; busy 0; issue counter 0; valid pipe 0.
- States: IDLE=0, RUN=1, DRAIN=2, DONE=3.
- IDLE:
  - start -> RUN.
  - Accumulators are cleared on the start edge.
- RUN, pop rule:
  - beat_ok = no A FIFO empty AND B FIFO not empty AND issue_cnt < VEC_LEN.
  - When beat_ok: all NUM_MACS fifo_a_rden bits and fifo_b_rden assert together for one cycle, and issue_cnt increments.
  - No partial pops. rden is never asserted to an empty FIFO.
  - A beat lost to empty stalls with no side effects.
- RUN -> DRAIN: in the cycle the VEC_LEN-th pop issues.
- Valid pipe:
  - A RD_LATENCY-deep shift register carries the pop strobe.
  - When its output is 1: acc[i] <= acc[i] + fifo_a_q[i]*fifo_b_q, unsigned, product zero-extended to ACC_WIDTH.
- DRAIN:
  - No pops.
  - -> DONE in the cycle the last in-flight beat accumulates, i.e. the valid pipe empties.
- DONE:
  - result_valid=1; result stable.
  - start -> RUN with accumulators cleared, result_valid drops.
- Latency: for a stall-free run, result_valid rises VEC_LEN+RD_LATENCY+1 cycles after the edge that samples start. This is 10 at the default parameters.
- busy = (state==RUN || state==DRAIN).
- Priorities:
  - rst > clr > start.
  - clr in any state -> IDLE next cycle: rden 0 that same cycle, accumulators and result zeroed, valid pipe flushed so in-flight data is discarded.
  - start while in RUN or DRAIN is ignored.
- Overflow: not possible with legal ACC_WIDTH; no saturation logic.
- result is driven directly from the accumulators. Consumers qualify it with result_valid.

Decomposition:
- Package matvec_pkg:
  - seq_state_t enum (2-bit, values above).
  - Default width constants DATA_WIDTH_D, ACC_WIDTH_D.
- Sub-module mac_unit, instantiated NUM_MACS times.
  - Inputs: clk, rst, clr_acc, en, a, b.
  - Output: acc.
  - Registered accumulate; clr_acc has priority over en.
- The sequencer owns the FSM, issue_cnt, valid pipe and rden generation.

Test Plan:
- Basic run: A row i all elements = i+1, B all 1, FIFOs prefilled, start pulse. Required: result[i] = 8*(i+1), i.e. 8,16,...,64; result_valid rises exactly 10 cycles after start; exactly 8 rden pulses per FIFO.
- Max values: all A and B elements = 255. Required: every result = 520200 (0x07F008); no wrap.
- Stall: hold fifo_b_empty=1 for 3 cycles after the 4th pop. Required: no rden during the stall; result_valid delayed to 13 cycles; results are the same as the unstalled run.
- Single-lane starvation: fifo_a_empty[5]=1 for 2 cycles. Required: no FIFO pops in those cycles; results correct.
- clr after the 5th pop. Required: next cycle state IDLE, result all 0, result_valid 0, no further rden; a following start with refilled FIFOs gives correct results, not added to the stale partial sums.
- Restart and reset:
  - Second start in DONE with B all 2: results double the prior ones.
  - rst asserted mid-DRAIN: all outputs at reset values on the next edge.
